// File: rtl/data_snippet_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : data_snippet_sampler
//  Purpose  : Armed/triggered snippet capture of a wide stream into a local
//             RAM, replayed as DOUT_WIDTH slices through an FWFT output port.
//  Revision : 1.0  initial release
// ============================================================================
module data_snippet_sampler #(
    parameter  int DIN_WIDTH  = 512,
    parameter  int DOUT_WIDTH = 32,
    parameter  int DEPTH      = 256,
    parameter  int SHIFTORDER = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  i_din,
    input  logic                  i_din_valid,
    input  logic                  i_arm,
    input  logic                  i_trig,
    input  logic                  i_abort,
    input  logic [AW:0]           i_nsamples,
    output logic                  o_busy,
    output logic [AW:0]           o_captured,
    output logic [DOUT_WIDTH-1:0] o_dout,
    output logic                  o_dout_empty,
    input  logic                  i_dout_rden
);
    localparam int          c_RATIO = DIN_WIDTH / DOUT_WIDTH;
    localparam int          c_CW    = $clog2(c_RATIO + 1);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW:0]           r_len;
    logic [AW:0]           r_captured;
    logic [AW:0]           r_rd_cnt;
    logic                  r_trig_pending;
    logic [DIN_WIDTH-1:0]  r_mem [DEPTH];
    logic [DIN_WIDTH-1:0]  r_ram_q;
    logic                  r_ram_vld;
    logic [DIN_WIDTH-1:0]  r_sr;
    logic [c_CW-1:0]       r_sr_cnt;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                  r_dout_empty;

    logic                  w_arm_ok, w_wr_en, w_rd_en, w_take_sr, w_take_ram;
    logic                  w_pop, w_out_free;
    logic [AW:0]           w_cap_inc;
    logic [AW:0]           w_len_clamp;
    logic [DOUT_WIDTH-1:0] w_q_first, w_sr_first;
    logic [DIN_WIDTH-1:0]  w_q_rest, w_sr_rest;

    assign w_pop       = i_dout_rden & ~r_dout_empty;
    assign w_out_free  = r_dout_empty | w_pop;
    assign w_cap_inc   = r_captured + c_ONE;
    assign w_len_clamp = (i_nsamples == '0 || i_nsamples > c_DEPTH) ? c_DEPTH : i_nsamples;

    generate
        if (SHIFTORDER != 0) begin : g_msb_first
            assign w_q_first  = r_ram_q[DIN_WIDTH-1 -: DOUT_WIDTH];
            assign w_q_rest   = r_ram_q << DOUT_WIDTH;
            assign w_sr_first = r_sr[DIN_WIDTH-1 -: DOUT_WIDTH];
            assign w_sr_rest  = r_sr << DOUT_WIDTH;
        end else begin : g_lsb_first
            assign w_q_first  = r_ram_q[DOUT_WIDTH-1:0];
            assign w_q_rest   = r_ram_q >> DOUT_WIDTH;
            assign w_sr_first = r_sr[DOUT_WIDTH-1:0];
            assign w_sr_rest  = r_sr >> DOUT_WIDTH;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_arm_ok    = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_take_sr   = 1'b0;
        w_take_ram  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_arm_ok    = 1'b1;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (i_din_valid && (i_trig || r_trig_pending)) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = (r_len == c_ONE) ? S_READOUT : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (i_din_valid) begin
                    w_wr_en = 1'b1;
                    if (w_cap_inc == r_len) w_state_nxt = S_READOUT;
                end
            end
            S_READOUT: begin
                // Shift register drains first; the RAM word waiting behind it
                // is the prefetch that hides the read latency between words.
                if (w_out_free) begin
                    if (r_sr_cnt != '0)      w_take_sr   = 1'b1;
                    else if (r_ram_vld)      w_take_ram  = 1'b1;
                    else if (r_rd_cnt == r_len) w_state_nxt = S_IDLE;
                end
                w_rd_en = (r_rd_cnt != r_len) && (!r_ram_vld || w_take_ram);
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_arm_ok    = 1'b0;
            w_wr_en     = 1'b0;
            w_rd_en     = 1'b0;
            w_take_sr   = 1'b0;
            w_take_ram  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len          <= '0;
            r_captured     <= '0;
            r_rd_cnt       <= '0;
            r_trig_pending <= 1'b0;
            r_ram_vld      <= 1'b0;
            r_sr           <= '0;
            r_sr_cnt       <= '0;
            r_dout         <= '0;
            r_dout_empty   <= 1'b1;
        end else begin
            if (i_abort || r_state != S_ARMED) r_trig_pending <= 1'b0;
            else if (i_trig)                   r_trig_pending <= 1'b1;

            if (w_arm_ok) begin
                r_len      <= w_len_clamp;
                r_captured <= '0;
                r_rd_cnt   <= '0;
            end
            if (w_wr_en) r_captured <= w_cap_inc;
            if (w_rd_en) r_rd_cnt   <= r_rd_cnt + c_ONE;

            if (i_abort || w_arm_ok) r_ram_vld <= 1'b0;
            else if (w_rd_en)        r_ram_vld <= 1'b1;
            else if (w_take_ram)     r_ram_vld <= 1'b0;

            if (w_take_sr) begin
                r_dout       <= w_sr_first;
                r_sr         <= w_sr_rest;
                r_sr_cnt     <= r_sr_cnt - 1'b1;
                r_dout_empty <= 1'b0;
            end else if (w_take_ram) begin
                r_dout       <= w_q_first;
                r_sr         <= w_q_rest;
                r_sr_cnt     <= c_CW'(c_RATIO - 1);
                r_dout_empty <= 1'b0;
            end else if (r_state == S_READOUT && w_out_free) begin
                r_dout_empty <= 1'b1;
            end

            if (i_abort || w_arm_ok) begin
                r_sr_cnt     <= '0;
                r_dout_empty <= 1'b1;
            end
        end
    end

    // Buffer has no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_captured[AW-1:0]] <= i_din;
        if (w_rd_en) r_ram_q <= r_mem[r_rd_cnt[AW-1:0]];
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_captured   = r_captured;
    assign o_dout       = r_dout;
    assign o_dout_empty = r_dout_empty;

endmodule
`default_nettype wire
